// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM: sequences the shared ALU, the unified memory port,
// the IR/PC registers and the register file write port over several cycles per instruction.
module multicycle_control_fsm #(
   parameter logic [3:0]  RESET_STATE = 4'd0,
   parameter int unsigned MEM_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_req,
   output logic       mem_we,
   output logic       reg_write,
   output logic [1:0] alu_srca,
   output logic [1:0] alu_srcb,
   output logic [3:0] alu_control,
   output logic [1:0] result_src,
   output logic       illegal_instr,
   output logic       mem_error,
   output logic [3:0] state
);

   localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10,
      S_JALR   = 4'd11,
      S_LUI    = 4'd12,
      S_AUIPC  = 4'd13,
      S_TRAP   = 4'd15
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_tmo_cnt;
   logic            r_illegal;
   logic            r_mem_error;
   logic            w_mem_req;
   logic            w_mem_we;
   logic            w_wait;
   logic            w_timeout;
   logic            w_set_illegal;

   // A request is outstanding in any memory state until mem_ready; mem_ready is ignored elsewhere.
   assign w_wait    = w_mem_req & ~mem_ready;
   assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && (r_tmo_cnt == CW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= state_t'(RESET_STATE);
         r_tmo_cnt   <= '0;
         r_illegal   <= 1'b0;
         r_mem_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_wait && !w_timeout)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         else
            r_tmo_cnt <= '0;
         if (w_timeout)
            r_mem_error <= 1'b1;
         if (w_set_illegal)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_set_illegal = 1'b0;
      w_mem_req     = 1'b0;
      w_mem_we      = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      adr_src       = 1'b0;
      reg_write     = 1'b0;
      alu_srca      = 2'b00;
      alu_srcb      = 2'b00;
      alu_control   = 4'b0000;
      result_src    = 2'b00;

      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_srcb   = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               w_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_srca = 2'b01;
            alu_srcb = 2'b01;
            case (opcode)
               7'b0000011,
               7'b0100011: w_next = S_MEMADR;
               7'b0110011: w_next = S_EXECR;
               7'b0010011: w_next = S_EXECI;
               7'b1100011: w_next = S_BRANCH;
               7'b1101111: w_next = S_JAL;
               7'b1100111: w_next = S_JALR;
               7'b0110111: w_next = S_LUI;
               7'b0010111: w_next = S_AUIPC;
               default: begin
                  w_next        = S_TRAP;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_srca = 2'b10;
            alu_srcb = 2'b01;
            w_next   = opcode[5] ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready)
               w_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready)
               w_next = S_FETCH;
         end
         S_EXECR: begin
            alu_srca    = 2'b10;
            alu_control = {funct3, funct7_5};
            w_next      = S_ALUWB;
         end
         S_EXECI: begin
            alu_srca    = 2'b10;
            alu_srcb    = 2'b01;
            alu_control = {funct3, (funct3 == 3'b101) ? funct7_5 : 1'b0};
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_srca    = 2'b10;
            alu_control = {funct3, 1'b1};
            pc_write    = branch_taken;
            w_next      = S_FETCH;
         end
         S_JAL: begin
            alu_srca = 2'b01;
            alu_srcb = 2'b10;
            pc_write = 1'b1;
            w_next   = S_ALUWB;
         end
         // JALR loads PC from the direct ALU result, then reuses the JAL cycle to form the link value;
         // the repeated PC load there writes the same target latched in ALU-out.
         S_JALR: begin
            alu_srca   = 2'b10;
            alu_srcb   = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            w_next     = S_JAL;
         end
         S_LUI: begin
            alu_srcb    = 2'b01;
            alu_control = 4'b1111;
            w_next      = S_ALUWB;
         end
         S_AUIPC: begin
            alu_srca = 2'b01;
            alu_srcb = 2'b01;
            w_next   = S_ALUWB;
         end
         S_TRAP: begin
            w_next = S_TRAP;
         end
         default: begin
            w_next = S_TRAP;
         end
      endcase

      if (w_timeout)
         w_next = S_TRAP;
   end

   // Asserting rst abandons any outstanding request in the same cycle.
   assign mem_req       = w_mem_req & ~rst;
   assign mem_we        = w_mem_we & ~rst;
   assign illegal_instr = r_illegal;
   assign mem_error     = r_mem_error;
   assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors push expected
// output snapshots; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       irw;
      logic       adr;
      logic       req;
      logic       we;
      logic       rw;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [3:0] ac;
      logic [1:0] rs;
      logic       ill;
      logic       me;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       branch_taken = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, adr_src, mem_req, mem_we, reg_write;
   logic [1:0] alu_srca, alu_srcb, result_src;
   logic [3:0] alu_control, state;
   logic       illegal_instr, mem_error;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t  q_exp[$];
   string q_nm[$];

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   multicycle_control_fsm #(
      .RESET_STATE (4'd0),
      .MEM_TIMEOUT (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7_5      (funct7_5),
      .branch_taken  (branch_taken),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .adr_src       (adr_src),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .reg_write     (reg_write),
      .alu_srca      (alu_srca),
      .alu_srcb      (alu_srcb),
      .alu_control   (alu_control),
      .result_src    (result_src),
      .illegal_instr (illegal_instr),
      .mem_error     (mem_error),
      .state         (state)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic irw,
                               input logic adr, input logic req, input logic we, input logic rw,
                               input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] ac,
                               input logic [1:0] rs, input logic ill, input logic me);
      exp_t e;
      e = '{st: st, pcw: pcw, irw: irw, adr: adr, req: req, we: we, rw: rw,
            sa: sa, sb: sb, ac: ac, rs: rs, ill: ill, me: me};
      return e;
   endfunction

   // One cycle: drive inputs just after the edge and queue the expected outputs for that cycle.
   task automatic cyc(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic bt, input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      opcode       = op;
      funct3       = f3;
      funct7_5     = f7;
      branch_taken = bt;
      mem_ready    = rdy;
      q_exp.push_back(e);
      q_nm.push_back(nm);
   endtask

   task automatic rst_pulse();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      mem_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (q_exp.size() != 0) begin
         exp_t  e;
         exp_t  g;
         string nm;
         e  = q_exp.pop_front();
         nm = q_nm.pop_front();
         g  = '{st: state, pcw: pc_write, irw: ir_write, adr: adr_src, req: mem_req,
                we: mem_we, rw: reg_write, sa: alu_srca, sb: alu_srcb, ac: alu_control,
                rs: result_src, ill: illegal_instr, me: mem_error};
         n_tests++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d pcw%b irw%b adr%b req%b we%b rw%b sa=%b sb=%b ac=%b rs=%b ill%b me%b, expected st=%0d pcw%b irw%b adr%b req%b we%b rw%b sa=%b sb=%b ac=%b rs=%b ill%b me%b",
                     nm, g.st, g.pcw, g.irw, g.adr, g.req, g.we, g.rw, g.sa, g.sb, g.ac, g.rs, g.ill, g.me,
                     e.st, e.pcw, e.irw, e.adr, e.req, e.we, e.rw, e.sa, e.sb, e.ac, e.rs, e.ill, e.me);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t E_FETCH_R, E_FETCH_W, E_DEC, E_ALUWB, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
      exp_t E_TRAP_I, E_TRAP_M;
      E_FETCH_R = mk(4'd0,  1,1,0,1,0,0, 2'b00,2'b10,4'b0000,2'b10, 0,0);
      E_FETCH_W = mk(4'd0,  0,0,0,1,0,0, 2'b00,2'b10,4'b0000,2'b10, 0,0);
      E_DEC     = mk(4'd1,  0,0,0,0,0,0, 2'b01,2'b01,4'b0000,2'b00, 0,0);
      E_MEMADR  = mk(4'd2,  0,0,0,0,0,0, 2'b10,2'b01,4'b0000,2'b00, 0,0);
      E_MEMRD   = mk(4'd3,  0,0,1,1,0,0, 2'b00,2'b00,4'b0000,2'b00, 0,0);
      E_MEMWB   = mk(4'd4,  0,0,0,0,0,1, 2'b00,2'b00,4'b0000,2'b01, 0,0);
      E_MEMWR   = mk(4'd5,  0,0,1,1,1,0, 2'b00,2'b00,4'b0000,2'b00, 0,0);
      E_ALUWB   = mk(4'd8,  0,0,0,0,0,1, 2'b00,2'b00,4'b0000,2'b00, 0,0);
      E_TRAP_I  = mk(4'd15, 0,0,0,0,0,0, 2'b00,2'b00,4'b0000,2'b00, 1,0);
      E_TRAP_M  = mk(4'd15, 0,0,0,0,0,0, 2'b00,2'b00,4'b0000,2'b00, 0,1);

      repeat (2) @(posedge clk);

      // ADD; mem_ready in DECODE must be ignored
      cyc("rst_fetch",  OP_R, 3'b000, 0, 0, 0, E_FETCH_W);
      cyc("add_fetch",  OP_R, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("add_dec",    OP_R, 3'b000, 0, 0, 1, E_DEC);
      cyc("add_execr",  OP_R, 3'b000, 0, 0, 0, mk(4'd6, 0,0,0,0,0,0, 2'b10,2'b00,4'b0000,2'b00, 0,0));
      cyc("add_aluwb",  OP_R, 3'b000, 0, 0, 0, E_ALUWB);
      cyc("add_ret",    OP_R, 3'b000, 0, 0, 0, E_FETCH_W);

      // LW with 3 wait cycles in MEMRD
      rst_pulse();
      cyc("lw_fetch",   OP_LOAD, 3'b010, 0, 0, 1, E_FETCH_R);
      cyc("lw_dec",     OP_LOAD, 3'b010, 0, 0, 0, E_DEC);
      cyc("lw_memadr",  OP_LOAD, 3'b010, 0, 0, 0, E_MEMADR);
      for (int i = 0; i < 3; i++)
         cyc("lw_memrd_wait", OP_LOAD, 3'b010, 0, 0, 0, E_MEMRD);
      cyc("lw_memrd_done", OP_LOAD, 3'b010, 0, 0, 1, E_MEMRD);
      cyc("lw_memwb",   OP_LOAD, 3'b010, 0, 0, 0, E_MEMWB);
      cyc("lw_ret",     OP_LOAD, 3'b010, 0, 0, 0, E_FETCH_W);

      // SW
      rst_pulse();
      cyc("sw_fetch",   OP_STORE, 3'b010, 0, 0, 1, E_FETCH_R);
      cyc("sw_dec",     OP_STORE, 3'b010, 0, 0, 0, E_DEC);
      cyc("sw_memadr",  OP_STORE, 3'b010, 0, 0, 0, E_MEMADR);
      cyc("sw_memwr",   OP_STORE, 3'b010, 0, 0, 1, E_MEMWR);
      cyc("sw_ret",     OP_STORE, 3'b010, 0, 0, 0, E_FETCH_W);

      // BEQ not taken, then taken
      rst_pulse();
      cyc("beq0_fetch", OP_BR, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("beq0_dec",   OP_BR, 3'b000, 0, 0, 0, E_DEC);
      cyc("beq0_br",    OP_BR, 3'b000, 0, 0, 0, mk(4'd9, 0,0,0,0,0,0, 2'b10,2'b00,4'b0001,2'b00, 0,0));
      cyc("beq0_ret",   OP_BR, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("beq1_dec",   OP_BR, 3'b000, 0, 1, 0, E_DEC);
      cyc("beq1_br",    OP_BR, 3'b000, 0, 1, 0, mk(4'd9, 1,0,0,0,0,0, 2'b10,2'b00,4'b0001,2'b00, 0,0));
      cyc("beq1_ret",   OP_BR, 3'b000, 0, 0, 0, E_FETCH_W);

      // SRAI and SLTI modifier handling
      rst_pulse();
      cyc("srai_fetch", OP_I, 3'b101, 1, 0, 1, E_FETCH_R);
      cyc("srai_dec",   OP_I, 3'b101, 1, 0, 0, E_DEC);
      cyc("srai_execi", OP_I, 3'b101, 1, 0, 0, mk(4'd7, 0,0,0,0,0,0, 2'b10,2'b01,4'b1011,2'b00, 0,0));
      cyc("srai_aluwb", OP_I, 3'b101, 1, 0, 0, E_ALUWB);
      cyc("slti_fetch", OP_I, 3'b010, 1, 0, 1, E_FETCH_R);
      cyc("slti_dec",   OP_I, 3'b010, 1, 0, 0, E_DEC);
      cyc("slti_execi", OP_I, 3'b010, 1, 0, 0, mk(4'd7, 0,0,0,0,0,0, 2'b10,2'b01,4'b0100,2'b00, 0,0));
      cyc("slti_aluwb", OP_I, 3'b010, 1, 0, 0, E_ALUWB);
      cyc("slti_ret",   OP_I, 3'b010, 1, 0, 0, E_FETCH_W);

      // JAL, JALR, LUI, AUIPC
      rst_pulse();
      cyc("jal_fetch",  OP_JAL, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("jal_dec",    OP_JAL, 3'b000, 0, 0, 0, E_DEC);
      cyc("jal_jal",    OP_JAL, 3'b000, 0, 0, 0, mk(4'd10, 1,0,0,0,0,0, 2'b01,2'b10,4'b0000,2'b00, 0,0));
      cyc("jal_aluwb",  OP_JAL, 3'b000, 0, 0, 0, E_ALUWB);
      cyc("jalr_fetch", OP_JALR, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("jalr_dec",   OP_JALR, 3'b000, 0, 0, 0, E_DEC);
      cyc("jalr_jalr",  OP_JALR, 3'b000, 0, 0, 0, mk(4'd11, 1,0,0,0,0,0, 2'b10,2'b01,4'b0000,2'b10, 0,0));
      cyc("jalr_link",  OP_JALR, 3'b000, 0, 0, 0, mk(4'd10, 1,0,0,0,0,0, 2'b01,2'b10,4'b0000,2'b00, 0,0));
      cyc("jalr_aluwb", OP_JALR, 3'b000, 0, 0, 0, E_ALUWB);
      cyc("lui_fetch",  OP_LUI, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("lui_dec",    OP_LUI, 3'b000, 0, 0, 0, E_DEC);
      cyc("lui_lui",    OP_LUI, 3'b000, 0, 0, 0, mk(4'd12, 0,0,0,0,0,0, 2'b00,2'b01,4'b1111,2'b00, 0,0));
      cyc("lui_aluwb",  OP_LUI, 3'b000, 0, 0, 0, E_ALUWB);
      cyc("auipc_fetch",OP_AUIPC, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("auipc_dec",  OP_AUIPC, 3'b000, 0, 0, 0, E_DEC);
      cyc("auipc_op",   OP_AUIPC, 3'b000, 0, 0, 0, mk(4'd13, 0,0,0,0,0,0, 2'b01,2'b01,4'b0000,2'b00, 0,0));
      cyc("auipc_aluwb",OP_AUIPC, 3'b000, 0, 0, 0, E_ALUWB);
      cyc("auipc_ret",  OP_AUIPC, 3'b000, 0, 0, 0, E_FETCH_W);

      // Illegal opcode: TRAP held 20 cycles, mem_ready ignored, reset clears the flag
      rst_pulse();
      cyc("bad_fetch",  OP_BAD, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("bad_dec",    OP_BAD, 3'b000, 0, 0, 0, E_DEC);
      for (int i = 0; i < 20; i++)
         cyc("bad_trap",  OP_BAD, 3'b000, 0, 0, 1'(i & 1), E_TRAP_I);
      rst_pulse();
      cyc("bad_rst_fetch", OP_R, 3'b000, 0, 0, 0, E_FETCH_W);

      // FETCH timeout after 8 waiting cycles
      rst_pulse();
      for (int i = 0; i < 8; i++)
         cyc("tmo_fetch_wait", OP_R, 3'b000, 0, 0, 0, E_FETCH_W);
      for (int i = 0; i < 3; i++)
         cyc("tmo_trap",  OP_R, 3'b000, 0, 0, 1, E_TRAP_M);
      rst_pulse();
      cyc("tmo_rst_fetch", OP_R, 3'b000, 0, 0, 1, E_FETCH_R);

      // Reset mid-load clears the timeout counter: 7 waits then ready must not time out
      rst_pulse();
      cyc("mid_fetch",  OP_LOAD, 3'b010, 0, 0, 1, E_FETCH_R);
      cyc("mid_dec",    OP_LOAD, 3'b010, 0, 0, 0, E_DEC);
      cyc("mid_memadr", OP_LOAD, 3'b010, 0, 0, 0, E_MEMADR);
      for (int i = 0; i < 5; i++)
         cyc("mid_memrd_wait", OP_LOAD, 3'b010, 0, 0, 0, E_MEMRD);
      rst_pulse();
      for (int i = 0; i < 7; i++)
         cyc("mid_fetch_wait", OP_R, 3'b000, 0, 0, 0, E_FETCH_W);
      cyc("mid_fetch_done", OP_R, 3'b000, 0, 0, 1, E_FETCH_R);
      cyc("mid_dec2",   OP_R, 3'b000, 0, 0, 0, E_DEC);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q_exp.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
